// File: rtl/dense_seq_ctrl.sv
// Frame sequencer for the serial int8 dense engine: clears the engine, streams D features at a
// 2-cycle cadence, captures B results and hands them downstream. Option: DENSE_SEQ_ARGMAX_EN.
module dense_seq_ctrl #(
  parameter int unsigned D          = 64,
  parameter int unsigned B          = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AW         = 6,
  parameter int unsigned CW         = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    fm_en_o,
  output logic [AW-1:0]           fm_addr_o,
  input  logic [DATA_WIDTH-1:0]   fm_data_i,
  output logic                    eng_rstn_o,
  output logic                    eng_valid_o,
  output logic [DATA_WIDTH-1:0]   eng_data_o,
  input  logic                    eng_valid_i,
  input  logic [B*DATA_WIDTH-1:0] eng_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [B*DATA_WIDTH-1:0] res_data_o,
`ifdef DENSE_SEQ_ARGMAX_EN
  output logic [CW-1:0]           class_o,
`endif
  output logic                    err_o
);

  if ((64'd1 << AW) < 64'(D)) begin : g_aw_chk
    $error("AW too narrow for D");
  end
  if ((64'd1 << CW) < 64'(B)) begin : g_cw_chk
    $error("CW too narrow for B");
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StIssue,
    StWaitRes,
`ifdef DENSE_SEQ_ARGMAX_EN
    StArgmax,
`endif
    StOut
  } state_e;

  localparam logic [AW-1:0] LastIdx = AW'(D - 1);

  state_e                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [B*DATA_WIDTH-1:0]   res_q, res_d;
  logic                      err_q, err_d;

`ifdef DENSE_SEQ_ARGMAX_EN
  localparam logic [CW-1:0] LastCls = CW'(B - 1);

  logic [CW-1:0]             scan_q, scan_d;
  logic [CW-1:0]             class_q, class_d;
  logic [DATA_WIDTH-1:0]     best_q, best_d;
  logic [DATA_WIDTH-1:0]     cur;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef DENSE_SEQ_ARGMAX_EN
      scan_q  <= '0;
      class_q <= '0;
      best_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef DENSE_SEQ_ARGMAX_EN
      scan_q  <= scan_d;
      class_q <= class_d;
      best_q  <= best_d;
`endif
    end
  end

`ifdef DENSE_SEQ_ARGMAX_EN
  always_comb begin
    cur = '0;
    for (int i = 0; i < int'(B); i++) begin
      if (scan_q == CW'(i)) cur = res_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    // A result beat is only legal while we are waiting for one.
    err_d   = err_q | (eng_valid_i && (state_q != StWaitRes));
`ifdef DENSE_SEQ_ARGMAX_EN
    scan_d  = scan_q;
    class_d = class_q;
    best_d  = best_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StClear;
      end
      StClear: begin
        idx_d   = '0;
        state_d = StFetch;
      end
      StFetch: begin
        state_d = StIssue;
      end
      StIssue: begin
        if (idx_q == LastIdx) begin
          state_d = StWaitRes;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StWaitRes: begin
        if (eng_valid_i) begin
          res_d = eng_data_i;
`ifdef DENSE_SEQ_ARGMAX_EN
          scan_d  = '0;
          state_d = StArgmax;
`else
          state_d = StOut;
`endif
        end
      end
`ifdef DENSE_SEQ_ARGMAX_EN
      StArgmax: begin
        // Strictly greater replaces, so ties keep the lowest class index.
        if ((scan_q == '0) || ($signed(cur) > $signed(best_q))) begin
          best_d  = cur;
          class_d = scan_q;
        end
        scan_d = scan_q + 1'b1;
        if (scan_q == LastCls) state_d = StOut;
      end
`endif
      StOut: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are gated by rstn so a reset takes effect on the outputs immediately.
  always_comb begin
    busy_o      = rstn && (state_q != StIdle);
    fm_en_o     = rstn && (state_q == StFetch);
    fm_addr_o   = fm_en_o ? idx_q : '0;
    eng_rstn_o  = rstn && (state_q != StClear);
    eng_valid_o = rstn && (state_q == StIssue);
    eng_data_o  = eng_valid_o ? fm_data_i : '0;
    res_valid_o = rstn && (state_q == StOut);
    res_data_o  = res_q;
    err_o       = err_q;
`ifdef DENSE_SEQ_ARGMAX_EN
    class_o     = class_q;
`endif
  end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Scoreboard bench for dense_seq_ctrl: features and results are queued as stimulus is driven
// and popped when the DUT emits them; cycle-exact schedule checks run alongside.
module tb_dense_seq_ctrl;
  localparam int unsigned D  = 64;
  localparam int unsigned B  = 7;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 3;
  localparam int RES_T = 2 * D + 3;
`ifdef DENSE_SEQ_ARGMAX_EN
  localparam int OUT_T = 2 * D + 4 + B;
`else
  localparam int OUT_T = 2 * D + 4;
`endif

  logic            clk;
  logic            rstn;
  logic            start_i;
  logic            busy_o;
  logic            fm_en_o;
  logic [AW-1:0]   fm_addr_o;
  logic [DW-1:0]   fm_data_i;
  logic            eng_rstn_o;
  logic            eng_valid_o;
  logic [DW-1:0]   eng_data_o;
  logic            eng_valid_i;
  logic [B*DW-1:0] eng_data_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [B*DW-1:0] res_data_o;
`ifdef DENSE_SEQ_ARGMAX_EN
  logic [CW-1:0]   class_o;
`endif
  logic            err_o;

  dense_seq_ctrl #(.D(D), .B(B), .DATA_WIDTH(DW), .AW(AW), .CW(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .fm_en_o    (fm_en_o),
    .fm_addr_o  (fm_addr_o),
    .fm_data_i  (fm_data_i),
    .eng_rstn_o (eng_rstn_o),
    .eng_valid_o(eng_valid_o),
    .eng_data_o (eng_data_o),
    .eng_valid_i(eng_valid_i),
    .eng_data_i (eng_data_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_data_o (res_data_o),
`ifdef DENSE_SEQ_ARGMAX_EN
    .class_o    (class_o),
`endif
    .err_o      (err_o)
  );

  logic [DW-1:0]   fm_mem [D];
  logic [DW-1:0]   feat_q [$];
  logic [B*DW-1:0] res_exp_q [$];
  logic [B*DW-1:0] last_res;
  bit              err_exp;
  int              n_checks;
  int              n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency feature buffer
  always @(posedge clk) begin
    if (!rstn) fm_data_i <= '0;
    else if (fm_en_o) fm_data_i <= fm_mem[fm_addr_o];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

`ifdef DENSE_SEQ_ARGMAX_EN
  function automatic logic [CW-1:0] argmax_ref(input logic [B*DW-1:0] r);
    logic signed [DW-1:0] best;
    logic signed [DW-1:0] v;
    logic [CW-1:0]        idx;
    best = r[DW-1:0];
    idx  = '0;
    for (int k = 1; k < int'(B); k++) begin
      v = r[k*DW +: DW];
      if (v > best) begin
        best = v;
        idx  = CW'(k);
      end
    end
    return idx;
  endfunction
`endif

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'(0));
    check_eq({tag, "_fm_en"}, 64'(fm_en_o), 64'(0));
    check_eq({tag, "_fm_addr"}, 64'(fm_addr_o), 64'(0));
    check_eq({tag, "_eng_rstn"}, 64'(eng_rstn_o), 64'(0));
    check_eq({tag, "_eng_valid"}, 64'(eng_valid_o), 64'(0));
    check_eq({tag, "_eng_data"}, 64'(eng_data_o), 64'(0));
    check_eq({tag, "_res_valid"}, 64'(res_valid_o), 64'(0));
    check_eq({tag, "_res_data"}, 64'(res_data_o), 64'(0));
    check_eq({tag, "_err"}, 64'(err_o), 64'(0));
`ifdef DENSE_SEQ_ARGMAX_EN
    check_eq({tag, "_class"}, 64'(class_o), 64'(0));
`endif
  endtask

  // Entered at posedge+1 of the IDLE cycle that is frame cycle 0; returns at posedge+1 of the
  // cycle after the handshake (or after the mid-frame reset sequence).
  task automatic run_frame(input logic [B*DW-1:0] result, input int hold, input bit keep_start,
                           input int pulse_rel, input int inj_rel, input int abort_rel);
    int hs;
    bit done;
    bit exp_fe;
    bit exp_ev;
    bit aborting;
    hs   = OUT_T + hold;
    done = 1'b0;
    for (int k = 0; k < int'(D); k++) feat_q.push_back(fm_mem[k]);
    for (int rel = 0; rel <= hs + 4; rel++) begin
      aborting    = (abort_rel >= 0) && (rel >= abort_rel);
      start_i     = (rel == 0) || keep_start || (rel == pulse_rel);
      res_ready_i = (rel >= hs);
      eng_valid_i = !aborting && ((rel == RES_T) || (rel == inj_rel));
      eng_data_i  = (rel == RES_T) ? result : ((rel == inj_rel) ? ~result : '0);
      if (aborting) begin
        start_i = 1'b0;
        rstn    = (rel >= abort_rel + 2);
      end
      if (eng_valid_i && rel == RES_T) res_exp_q.push_back(result);
      #4;
      if (aborting) begin
        if (rel == abort_rel) begin
          check_eq("abort_eng_rstn", 64'(eng_rstn_o), 64'(0));
          check_eq("abort_eng_valid", 64'(eng_valid_o), 64'(0));
        end else if (rel == abort_rel + 1) begin
          check_reset_outputs("abort");
        end else begin
          check_eq("post_abort_busy", 64'(busy_o), 64'(0));
          check_eq("post_abort_eng_rstn", 64'(eng_rstn_o), 64'(1));
          feat_q.delete();
          err_exp  = 1'b0;
          last_res = '0;
          done     = 1'b1;
        end
      end else begin
        check_eq("busy", 64'(busy_o), 64'(rel >= 1 && rel <= hs));
        check_eq("eng_rstn", 64'(eng_rstn_o), 64'(rel != 1));
        exp_fe = (rel >= 2) && (rel <= 2 * int'(D)) && (rel % 2 == 0);
        check_eq("fm_en", 64'(fm_en_o), 64'(exp_fe));
        if (exp_fe) check_eq("fm_addr", 64'(fm_addr_o), 64'((rel - 2) / 2));
        exp_ev = (rel >= 3) && (rel <= 2 * int'(D) + 1) && (rel % 2 == 1);
        check_eq("eng_valid", 64'(eng_valid_o), 64'(exp_ev));
        if (eng_valid_o && feat_q.size() > 0) check_eq("eng_data", 64'(eng_data_o),
                                                       64'(feat_q.pop_front()));
        else if (!eng_valid_o) check_eq("eng_data_idle", 64'(eng_data_o), 64'(0));
        check_eq("res_valid", 64'(res_valid_o), 64'(rel >= OUT_T && rel <= hs));
        if (rel <= RES_T) check_eq("res_hold", 64'(res_data_o), 64'(last_res));
        if (res_valid_o) begin
          check_eq("res_data", 64'(res_data_o), 64'(result));
`ifdef DENSE_SEQ_ARGMAX_EN
          check_eq("class", 64'(class_o), 64'(argmax_ref(result)));
`endif
        end
        if (res_valid_o && res_ready_i && res_exp_q.size() > 0)
          check_eq("res_sb", 64'(res_data_o), 64'(res_exp_q.pop_front()));
        check_eq("err", 64'(err_o), 64'(err_exp));
        if (rel == inj_rel) err_exp = 1'b1;
        if (rel == hs) begin
          last_res = result;
          done     = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    check_eq("frame_done", 64'(done), 64'(1));
    check_eq("feat_sb_empty", 64'(feat_q.size()), 64'(0));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rstn        = 1'b0;
    start_i     = 1'b0;
    eng_valid_i = 1'b0;
    eng_data_i  = '0;
    res_ready_i = 1'b0;
    err_exp     = 1'b0;
    last_res    = '0;
    for (int k = 0; k < int'(D); k++) fm_mem[k] = DW'(k);

    repeat (2) @(posedge clk);
    #5;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with 10 cycles of downstream backpressure.
    run_frame(56'h7F80010203FE05, 10, 1'b0, -1, -1, -1);
    // start_i held high across two back-to-back frames.
    run_frame(56'h0123456789ABCD, 0, 1'b1, -1, -1, -1);
    run_frame(56'hA5A55A5A00FF11, 0, 1'b1, -1, -1, -1);
    start_i = 1'b0;
    // Stray start during FETCH and a stray engine beat at cycle 20.
    run_frame(56'h10203040506070, 0, 1'b0, 4, 20, -1);
    // Reset in the middle of a frame, then a clean frame.
    run_frame(56'hDEADBEEFCAFE01, 0, 1'b0, -1, -1, 50);
    run_frame(56'h02090900FF0903, 2, 1'b0, -1, -1, -1);
    // Class results {3,9,9,-1,0,9,2} and all -128.
    run_frame(56'h020900FF090903, 0, 1'b0, -1, -1, -1);
    run_frame(56'h80808080808080, 0, 1'b0, -1, -1, -1);

    start_i = 1'b0;
    #4;
    check_eq("final_busy", 64'(busy_o), 64'(0));
    check_eq("final_res_hold", 64'(res_data_o), 64'(last_res));
    check_eq("final_err", 64'(err_o), 64'(err_exp));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dense_seq_ctrl.md
# dense_seq_ctrl

Frame sequencer for the serial integer dense engine (the `D`-deep, `B`-wide int8 MAC layer with ROM kernels and a one-cycle kernel-fetch wait per input). On `start_i` it clears the engine's accumulators, streams `D` feature bytes from a 1-cycle-latency feature buffer at the engine's required 2-cycle cadence, and captures the engine's `B` saturated outputs. It then presents them downstream on a valid/ready handshake, optionally with an argmax class index. It sits between the flattened feature-map buffer and the classifier output stage.

## Interface
Parameters:
- `D`, default 64: number of input features per frame (engine depth).
- `B`, default 7: number of engine outputs (classes).
- `DATA_WIDTH`, default 8: feature and result element width.
- `AW`, default 6: feature-buffer address width; must satisfy 2^AW ≥ D.
- `CW`, default 3: class-index width; must satisfy 2^CW ≥ B.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset; synchronous, active-low.
- `start_i`, in, 1: frame request; sampled only in IDLE.
- `busy_o`, out, 1: high in every state except IDLE.
- `fm_en_o`, out, 1: feature-buffer read enable.
- `fm_addr_o`, out, AW: feature-buffer read address.
- `fm_data_i`, in, DATA_WIDTH: read data, valid the cycle after `fm_en_o`.
- `eng_rstn_o`, out, 1: engine reset; equals `rstn & ~(state==CLEAR)`.
- `eng_valid_o`, out, 1: engine `valid_i`.
- `eng_data_o`, out, DATA_WIDTH: engine `data_i`.
- `eng_valid_i`, in, 1: engine `valid_o`.
- `eng_data_i`, in, B*DATA_WIDTH: engine `data_o`.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: downstream ready.
- `res_data_o`, out, B*DATA_WIDTH: captured results; class k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `class_o`, out, CW: argmax index; present only with `DENSE_SEQ_ARGMAX_EN`.
- `err_o`, out, 1: sticky protocol error; cleared only by reset.

## Operation
- Reset values: all outputs 0 (including `eng_rstn_o`, because it follows `rstn`); state IDLE; index counter 0; result register 0.
- IDLE: if `start_i`=1, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): `eng_rstn_o`=0, which zeroes the engine accumulators and its `d_cnt`. Index counter is set to 0. Go to FETCH.
- FETCH (1 cycle): `fm_en_o`=1, `fm_addr_o`=index, `eng_valid_o`=0. This cycle doubles as the engine's kernel-wait cycle. Go to ISSUE.
- ISSUE (1 cycle): `eng_valid_o`=1 and `eng_data_o`=`fm_data_i` (combinational pass-through). If index = D-1, go to WAIT_RES. Otherwise increment the index and go to FETCH.
- `eng_data_o` is 0 whenever `eng_valid_o`=0.
- WAIT_RES: on `eng_valid_i`=1, register `eng_data_i` into the result register.
  - Without the macro, go to OUT.
  - With the macro, go to ARGMAX.
  - There is no timeout.
- ARGMAX (B cycles, macro only): serial scan k = 0..B-1 using a signed DATA_WIDTH compare. Strictly-greater replaces the current best, so ties keep the lower index. Go to OUT.
- OUT: `res_valid_o`=1, with `res_data_o` and `class_o` stable. On `res_valid_o & res_ready_i`, go to IDLE.
- `res_data_o` holds the last result after the handshake, until the next capture.
- `start_i` outside IDLE is ignored and not queued.
- If `start_i` is held high, it is accepted again in the IDLE cycle that follows OUT.
- `eng_valid_i`=1 in any state other than WAIT_RES sets `err_o`; the data is not captured.
- Reset mid-frame: the next state is IDLE, all outputs take their reset values, and the engine is reset through `eng_rstn_o`. A later `start_i` runs a clean frame.

## Timing
- Cycle 0: IDLE with `start_i`=1.
- Cycle 1: CLEAR.
- Cycle 2+2k: FETCH for feature k.
- Cycle 3+2k: ISSUE for feature k.
- Last ISSUE is at cycle 2D+1. With the engine's 2-cycle latency, `eng_valid_i` arrives at cycle 2D+3.
- `res_valid_o` first high: cycle 2D+4 without the macro, 2D+4+B with it. For the defaults this is cycle 132, or 139 with the macro.
- Minimum start-to-start spacing: 2D+5 cycles (+B with the macro), assuming `res_ready_i`=1.
- `eng_valid_o` is never high in two consecutive cycles; spacing is exactly 2 cycles.

## Configuration
- `DENSE_SEQ_ARGMAX_EN` defined:
  - The ARGMAX state and the `class_o` port exist.
  - `class_o` is reset to 0 and updated before OUT.
- Not defined:
  - No ARGMAX state and no `class_o` port.
  - WAIT_RES goes directly to OUT.

## Test plan
- Buffer fm[k]=k, `start_i` at cycle 0: `fm_addr_o`=k at cycle 2+2k; `eng_valid_o` pulses at odd cycles 3..129 with `eng_data_o`=k; `eng_rstn_o` low only at cycle 1.
- Engine model returns 0x7F80010203FE05 at cycle 131: `res_valid_o` rises at 132 with that value; hold `res_ready_i`=0 for 10 cycles → value stable; handshake at 142 → `busy_o`=0 at 143.
- Hold `start_i`=1 for two frames: exactly two CLEAR cycles, two groups of 64 pulses, and no overlap between frames.
- Pulse `start_i` during FETCH → ignored; inject `eng_valid_i` at cycle 20 → `err_o`=1 and stays 1; the result is not captured.
- Assert `rstn`=0 at cycle 50 for 2 cycles → all outputs 0 and `eng_rstn_o`=0; a new start completes normally.
- With `DENSE_SEQ_ARGMAX_EN`, results {3,9,9,-1,0,9,2} (k=0..6) → `class_o`=1 at `res_valid_o` (cycle 139); results all -128 → `class_o`=0.
